// File: rtl/angle_reducer.sv
// Sequential angle reducer: subtracts 360 once per cycle, then folds into quadrant and 0..89 offset.
// Optional input range check (inputs above 720 flagged with out_err) enabled by macro ANGLE_RANGE_CHECK_EN.
module angle_reducer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_angle,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_angle,
  output logic [1:0]            out_quad,
  output logic                  out_sin_neg,
  output logic                  out_cos_neg,
  output logic                  out_err
);

  localparam logic [DATA_WIDTH-1:0] DEG90  = DATA_WIDTH'(90);
  localparam logic [DATA_WIDTH-1:0] DEG180 = DATA_WIDTH'(180);
  localparam logic [DATA_WIDTH-1:0] DEG270 = DATA_WIDTH'(270);
  localparam logic [DATA_WIDTH-1:0] DEG360 = DATA_WIDTH'(360);

  typedef enum logic [1:0] {IDLE, REDUCE, FOLD, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic                  err_pend;
  logic                  too_big;
  logic [1:0]            q_fold;
  logic [DATA_WIDTH-1:0] angle_fold;

  // Quadrant of an angle already below 360, found by threshold compares.
  function automatic logic [1:0] fold_quad(input logic [DATA_WIDTH-1:0] a);
    if (a >= DEG270)      fold_quad = 2'd3;
    else if (a >= DEG180) fold_quad = 2'd2;
    else if (a >= DEG90)  fold_quad = 2'd1;
    else                  fold_quad = 2'd0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fold_angle(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [1:0] q);
    case (q)
      2'd3:    fold_angle = a - DEG270;
      2'd2:    fold_angle = a - DEG180;
      2'd1:    fold_angle = a - DEG90;
      default: fold_angle = a;
    endcase
  endfunction

`ifdef ANGLE_RANGE_CHECK_EN
  assign too_big = (in_angle > DATA_WIDTH'(720));
`else
  assign too_big = 1'b0;
`endif

  assign q_fold     = fold_quad(acc);
  assign angle_fold = fold_angle(acc, q_fold);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      acc         <= '0;
      err_pend    <= 1'b0;
      out_angle   <= '0;
      out_quad    <= 2'd0;
      out_sin_neg <= 1'b0;
      out_cos_neg <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= in_angle;
            err_pend <= too_big;
            in_ready <= 1'b0;
            state    <= REDUCE;
          end
        end
        REDUCE: begin
          // Out-of-range inputs bypass reduction and report zeroed data with the error flag.
          if (err_pend) begin
            out_angle   <= '0;
            out_quad    <= 2'd0;
            out_sin_neg <= 1'b0;
            out_cos_neg <= 1'b0;
            out_err     <= 1'b1;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else if (acc >= DEG360) begin
            acc <= acc - DEG360;
          end else begin
            state <= FOLD;
          end
        end
        FOLD: begin
          out_angle   <= angle_fold;
          out_quad    <= q_fold;
          out_sin_neg <= q_fold[1];
          out_cos_neg <= q_fold[1] ^ q_fold[0];
          out_err     <= 1'b0;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_angle_reducer.sv
// Self-checking bench for angle_reducer: vector table, hand-written corner sequences,
// random transactions and a back-to-back 0..720 sweep checked against a mod-360 reference.
module tb_angle_reducer;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_angle;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_angle;
  logic [1:0]   out_quad;
  logic         out_sin_neg;
  logic         out_cos_neg;
  logic         out_err;

  int checks = 0;
  int errors = 0;

  angle_reducer #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_angle(out_angle), .out_quad(out_quad),
    .out_sin_neg(out_sin_neg), .out_cos_neg(out_cos_neg), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] angle;
    logic [W-1:0] exp_angle;
    logic [1:0]   exp_quad;
    logic         exp_sin;
    logic         exp_cos;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

`ifdef ANGLE_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference decomposition straight from the arithmetic definition.
  task automatic ref_model(input logic [W-1:0] a, output vec_t v);
    logic [W-1:0] r;
    v.angle = a;
    if (RANGE_CHK && a > 720) begin
      v.exp_angle = 0; v.exp_quad = 0; v.exp_sin = 0; v.exp_cos = 0;
      v.exp_err = 1; v.exp_lat = 1;
    end else begin
      r = a % 360;
      v.exp_angle = r % 90;
      v.exp_quad  = 2'(r / 90);
      v.exp_sin   = (v.exp_quad >= 2);
      v.exp_cos   = (v.exp_quad == 1 || v.exp_quad == 2);
      v.exp_err   = 0;
      v.exp_lat   = 2 + int'(a / 360);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: transfer, wait for result, hold with out_ready low, then release.
  task automatic run_txn(input string tag, input vec_t v, input int hold);
    int n;
    int lat;
    logic [W-1:0] cap_angle;
    logic [1:0] cap_quad;
    logic cap_s, cap_c, cap_e;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    in_angle = v.angle;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 300) begin tick(); lat++; end
    chk({tag, "_lat"}, W'(lat), W'(v.exp_lat));
    chk({tag, "_angle"}, out_angle, v.exp_angle);
    chk({tag, "_quad"}, W'(out_quad), W'(v.exp_quad));
    chk({tag, "_sin"}, W'(out_sin_neg), W'(v.exp_sin));
    chk({tag, "_cos"}, W'(out_cos_neg), W'(v.exp_cos));
    chk({tag, "_err"}, W'(out_err), W'(v.exp_err));
    cap_angle = out_angle; cap_quad = out_quad;
    cap_s = out_sin_neg; cap_c = out_cos_neg; cap_e = out_err;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_angle = 7;
      tick();
      chk({tag, "_hold_stable"},
          W'(out_valid && out_angle == cap_angle && out_quad == cap_quad &&
             out_sin_neg == cap_s && out_cos_neg == cap_c && out_err == cap_e), 1);
      chk({tag, "_hold_in_ready"}, W'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_release_valid"}, W'(out_valid), 0);
    chk({tag, "_release_ready"}, W'(in_ready), 1);
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    int idx, got, cyc;
    logic [W-1:0] q[$];
    logic [W-1:0] a;
    bit seen_valid;

    tbl[0]  = '{0,    0,  0, 0, 0, 0, 2};
    tbl[1]  = '{360,  0,  0, 0, 0, 0, 3};
    tbl[2]  = '{720,  0,  0, 0, 0, 0, 4};
    tbl[3]  = '{89,   89, 0, 0, 0, 0, 2};
    tbl[4]  = '{90,   0,  1, 0, 1, 0, 2};
    tbl[5]  = '{359,  89, 3, 1, 0, 0, 2};
    tbl[6]  = '{45,   45, 0, 0, 0, 0, 2};
    tbl[7]  = '{200,  20, 2, 1, 1, 0, 2};
    tbl[8]  = '{180,  0,  2, 1, 1, 0, 2};
    tbl[9]  = '{270,  0,  3, 1, 0, 0, 2};
    tbl[10] = '{1000, 10, 3, 1, 0, 0, 4};
    if (RANGE_CHK) tbl[11] = '{721, 0, 0, 0, 0, 1, 1};
    else           tbl[11] = '{721, 1, 0, 0, 0, 0, 4};
    if (RANGE_CHK) tbl[10] = '{1000, 0, 0, 0, 0, 1, 1};

    rst = 1'b1; in_valid = 1'b0; in_angle = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_in_ready", W'(in_ready), 1);
    chk("reset_out_valid", W'(out_valid), 0);
    chk("reset_out_angle", out_angle, 0);
    chk("reset_out_flags", W'({out_quad, out_sin_neg, out_cos_neg, out_err}), 0);

    for (int i = 0; i < 12; i++)
      run_txn($sformatf("tbl%0d", i), tbl[i], 0);

    ref_model(200, v);
    run_txn("hold200", v, 5);

    // Reset while mid-reduction of 1000: result must be discarded.
    in_angle = 1000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", W'(in_ready), 1);
    chk("midrst_out_valid", W'(out_valid), 0);
    chk("midrst_out_data", W'({out_angle != 0, out_quad, out_sin_neg, out_cos_neg, out_err}), 0);
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen_valid = 1;
    end
    chk("midrst_no_pulse", W'(seen_valid), 0);
    ref_model(90, v);
    run_txn("after_rst90", v, 0);

    for (int i = 0; i < 20; i++) begin
      a = W'($urandom_range(0, 20000));
      ref_model(a, v);
      run_txn($sformatf("rand%0d_a%0d", i, a), v, $urandom_range(0, 2));
    end

    // Back-to-back sweep with random downstream backpressure.
    idx = 0; got = 0; cyc = 0;
    while (got < 721 && cyc < 30000) begin
      in_valid  = (idx <= 720);
      in_angle  = W'(idx);
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin
        q.push_back(W'(idx));
        idx++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("sweep_spurious_result", 1, 0);
        end else begin
          a = q.pop_front();
          ref_model(a, v);
          chk($sformatf("sweep_a%0d", a),
              W'({out_angle[7:0], out_quad, out_sin_neg, out_cos_neg, out_err}),
              W'({v.exp_angle[7:0], v.exp_quad, v.exp_sin, v.exp_cos, v.exp_err}));
        end
        got++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("sweep_count", W'(got), 721);
    chk("sweep_sent", W'(idx), 721);
    chk("sweep_queue_empty", W'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/angle_reducer.md
ANGLE_REDUCER -- requirements
Module: angle_reducer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of input angle and reduced output angle (unsigned integer degrees).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_angle valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an angle.
REQ-006 SHALL have port in_angle  input  DATA_WIDTH  unsigned angle in degrees.
REQ-007 SHALL have port out_valid  output  1  result valid.
REQ-008 SHALL have port out_ready  input  1  downstream divider accepts result.
REQ-009 SHALL have port out_angle  output  DATA_WIDTH  reduced angle, 0..89.
REQ-010 SHALL have port out_quad  output  2  quadrant 0..3 of the angle mod 360.
REQ-011 SHALL have port out_sin_neg  output  1  sine negative (quadrants 2, 3).
REQ-012 SHALL have port out_cos_neg  output  1  cosine negative (quadrants 1, 2).
REQ-013 SHALL have port out_err  output  1  out-of-range input flag (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, REDUCE, FOLD, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; transfer occurs on an edge with in_valid=1 and in_ready=1.
REQ-016 On transfer, the FSM SHALL load acc=in_angle and go to REDUCE.
REQ-017 In REDUCE, each cycle: if acc>=360 then acc<=acc-360 and stay; else go to FOLD.
REQ-018 In FOLD (one cycle), the FSM SHALL set q=acc/90 (compare-based, no divider), out_angle=acc-90*q, out_quad=q, out_sin_neg=(q>=2), out_cos_neg=(q==1||q==2), then go to DONE.
REQ-019 Latency: transfer at edge N, k=floor(in_angle/360); out_valid SHALL be 1 after edge N+2+k.
REQ-020 In DONE, out_valid=1; all out_* SHALL hold stable until an edge with out_ready=1, then go to IDLE with out_valid=0.
REQ-021 out_ready while not in DONE SHALL be ignored; in_valid outside IDLE SHALL be ignored.
REQ-022 Boundary values: 0/360/720 -> angle 0, quad 0; 89 -> 89, q0; 90 -> 0, q1; 359 -> 89, q3.
REQ-023 Every cycle SHALL perform at most one subtraction of 360; no combinational path from in_* to out_*.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and clear out_valid, out_angle, out_quad, out_sin_neg, out_cos_neg, out_err, and acc to 0; in_ready=1 after the edge.
REQ-025 rst SHALL take priority over every handshake; an in-flight reduction SHALL be discarded with no out_valid pulse.

Configuration
REQ-026 Macro ANGLE_RANGE_CHECK_EN SHALL select input range checking.
REQ-027 With ANGLE_RANGE_CHECK_EN defined, an input >720 SHALL skip REDUCE/FOLD and reach DONE after edge N+1 with out_err=1, other out_* data=0.
REQ-028 With ANGLE_RANGE_CHECK_EN defined, inputs 0..720 SHALL have out_err=0.
REQ-029 Without ANGLE_RANGE_CHECK_EN, out_err SHALL be constant 0 and any input SHALL be reduced per REQ-017..019.

Verification
REQ-030 Reset, then in_angle=45 at edge N -> out_valid after N+2, angle 45, quad 0, sin_neg 0, cos_neg 0.
REQ-031 in_angle=720 -> out_valid after N+4, angle 0, quad 0; in_angle=359 -> after N+2, angle 89, quad 3, sin_neg 1, cos_neg 0.
REQ-032 in_angle=200 with out_ready=0 for 5 cycles -> angle 20, quad 2, both neg flags 1, held stable; in_ready=0 throughout; release after out_ready edge.
REQ-033 rst=1 asserted while in REDUCE for 1000 -> no out_valid, all outputs 0, in_ready=1 next cycle; new input 90 -> angle 0, quad 1, cos_neg 1.
REQ-034 in_angle=721: with ANGLE_RANGE_CHECK_EN -> out_err=1 after N+1; without -> after N+4, angle 1, quad 0, out_err 0.
REQ-035 Sweep 0..720 back-to-back with random out_ready -> every result matches (a mod 360) decomposition; no lost or duplicated transfers.
